// File: rtl/pulp_clk_gate_pkg.sv
// Shared types and parameter limits for the multi-channel asynchronous clock gate.
// The channel FSM enum lives here so checkers can decode per-channel state by name.
package pulp_clk_gate_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        ON       = 2'd1,
        OFF_HOLD = 2'd2,
        ON_HOLD  = 2'd3
    } gate_state_e;

    localparam int unsigned NUM_CH_MIN      = 1;
    localparam int unsigned NUM_CH_MAX      = 32;
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;
    localparam int unsigned MIN_DWELL_MAX   = 255;

    // Dwell counter width: max(1, clog2(dwell+1)); a zero dwell still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned dwell);
        int unsigned w;
        w = $clog2(dwell + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pulp_clock_gating.sv
// Latch-based leaf clock gate: enable is captured while clk_i is low, so clk_o
// can only change on the rising edge of clk_i and never glitches.
module pulp_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_latch;

    always_latch begin
        if (!clk_i) begin
            en_latch = en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/pulp_clock_gating_async_ch.sv
// One gated-clock channel: enable synchronizer, dwell-hold FSM with down-counter,
// and the leaf gate driven from the registered gate state.
module pulp_clock_gating_async_ch
    import pulp_clk_gate_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_DWELL   = 4,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_async_i,
    input  logic test_en_i,
    output logic en_ack_o,
    output logic busy_o,
    output logic clk_o
);

    localparam int unsigned     CNT_W    = cnt_width(MIN_DWELL);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(MIN_DWELL);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   en_sync;
    gate_state_e            state_q;
    gate_state_e            state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   gate_q;
    logic                   gate_d;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], en_async_i};
    assign en_sync = sync_q[SYNC_STAGES-1];

    // State register: reset aborts any hold in progress and reloads the idle state.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_q  <= {SYNC_STAGES{RST_VAL}};
            state_q <= RST_VAL ? ON : OFF;
            cnt_q   <= '0;
            gate_q  <= RST_VAL;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gate_q  <= gate_d;
        end
    end

    // Next-state logic: the request is ignored while holding, so a pulse that
    // flips back mid-hold is only re-evaluated once the dwell has elapsed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            OFF: begin
                if (en_sync) begin
                    if (MIN_DWELL == 0) begin
                        state_d = ON;
                    end else begin
                        state_d = ON_HOLD;
                        cnt_d   = DWELL_LD;
                    end
                end
            end
            ON: begin
                if (!en_sync) begin
                    if (MIN_DWELL == 0) begin
                        state_d = OFF;
                    end else begin
                        state_d = OFF_HOLD;
                        cnt_d   = DWELL_LD;
                    end
                end
            end
            OFF_HOLD: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ON_HOLD: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: gate follows the next state so the gate register tracks the FSM.
    always_comb begin
        gate_d = (state_d == ON) || (state_d == ON_HOLD);
        busy_o = en_sync ^ gate_q;
    end

    assign en_ack_o = gate_q;

    pulp_clock_gating i_leaf_gate (
        .clk_i     (clk_i),
        .en_i      (gate_q),
        .test_en_i (test_en_i),
        .clk_o     (clk_o)
    );

endmodule

// File: rtl/pulp_clock_gating_async_mc.sv
// Multi-channel clock gate with asynchronous per-channel enable requests.
// Channels are independent; all share clk_i, rstn_i and the scan test enable.
module pulp_clock_gating_async_mc
    import pulp_clk_gate_pkg::*;
#(
    parameter int unsigned       NUM_CH      = 4,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       MIN_DWELL   = 4,
    parameter logic [NUM_CH-1:0] RST_VAL     = '0
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NUM_CH-1:0] en_async_i,
    input  logic              test_en_i,
    output logic [NUM_CH-1:0] en_ack_o,
    output logic [NUM_CH-1:0] busy_o,
    output logic [NUM_CH-1:0] clk_o
);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("NUM_CH out of range 1..32");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("SYNC_STAGES out of range 2..4");
    end
    if (MIN_DWELL > MIN_DWELL_MAX) begin : g_bad_dwell
        $error("MIN_DWELL out of range 0..255");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulp_clock_gating_async_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .MIN_DWELL   (MIN_DWELL),
            .RST_VAL     (RST_VAL[i])
        ) i_ch (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .en_async_i (en_async_i[i]),
            .test_en_i  (test_en_i),
            .en_ack_o   (en_ack_o[i]),
            .busy_o     (busy_o[i]),
            .clk_o      (clk_o[i])
        );
    end

endmodule

// File: tb/tb_pulp_clock_gating_async_mc.sv
// Directed bench for the multi-channel clock gate: stimulus pushes the expected
// {en_ack_o, busy_o} after each edge; a monitor pops and compares on negedges.
module tb_pulp_clock_gating_async_mc;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned MIN_DWELL   = 4;
    localparam logic [3:0]  RST_VAL     = 4'b0001;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b0;
    logic       test_en  = 1'b0;
    logic [3:0] en_async = 4'b0001;
    logic [3:0] en_ack;
    logic [3:0] busy;
    logic [3:0] clk_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    pulp_clock_gating_async_mc #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_DWELL   (MIN_DWELL),
        .RST_VAL     (RST_VAL)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .en_async_i (en_async),
        .test_en_i  (test_en),
        .en_ack_o   (en_ack),
        .busy_o     (busy),
        .clk_o      (clk_o)
    );

    // Clock / reset
    initial forever #5 clk = ~clk;

    // Driver: apply inputs for the next rising edge and queue the state expected after it.
    task automatic cyc(input logic r, input logic [3:0] en, input logic t,
                       input logic [3:0] exp_ack, input logic [3:0] exp_busy,
                       input string nm);
        @(negedge clk);
        #1;
        rstn     = r;
        en_async = en;
        test_en  = t;
        exp_q.push_back({exp_ack, exp_busy});
        name_q.push_back(nm);
    endtask

    task automatic cyc_n(input int n, input logic [3:0] en, input logic t,
                         input logic [3:0] exp_ack, input logic [3:0] exp_busy,
                         input string nm);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, en, t, exp_ack, exp_busy, nm);
        end
    endtask

    // Gated clock check over four cycles: toggling means high after every posedge
    // and low after every negedge; gated means never high.
    task automatic check_clk(input logic [3:0] exp_tog, input string nm);
        int  hi[4];
        int  lo[4];
        logic ok;
        for (int i = 0; i < 4; i++) begin
            hi[i] = 0;
            lo[i] = 0;
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) if (clk_o[i]) hi[i]++;
            @(negedge clk);
            #1;
            for (int i = 0; i < 4; i++) if (!clk_o[i]) lo[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            ok = exp_tog[i] ? (hi[i] == 4 && lo[i] == 4) : (hi[i] == 0);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s ch%0d: high=%0d low=%0d of 4, expected toggling=%b",
                         nm, i, hi[i], lo[i], exp_tog[i]);
            end
        end
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [7:0] e;
                string      n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if ({en_ack, busy} !== e) begin
                    errors++;
                    $display("FAIL %s: en_ack=%b busy=%b expected en_ack=%b busy=%b",
                             n, en_ack, busy, e[7:4], e[3:0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        // Reset with ch0 held on through RST_VAL and its request.
        for (int k = 0; k < 3; k++) cyc(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0000, "reset");
        cyc(1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0000, "reset_release");
        check_clk(4'b0001, "reset_clk");

        // Turn-on ch1: busy after edge 1, ack after edge 2, then the dwell.
        cyc(1'b1, 4'b0011, 1'b0, 4'b0001, 4'b0000, "on_e0");
        cyc(1'b1, 4'b0011, 1'b0, 4'b0001, 4'b0010, "on_e1");
        cyc(1'b1, 4'b0011, 1'b0, 4'b0011, 4'b0000, "on_e2");
        cyc_n(4, 4'b0011, 1'b0, 4'b0011, 4'b0000, "on_hold");

        // One-cycle pulse on ch2 is stretched to MIN_DWELL+1 cycles.
        cyc(1'b1, 4'b0111, 1'b0, 4'b0011, 4'b0000, "glitch_e0");
        cyc(1'b1, 4'b0011, 1'b0, 4'b0011, 4'b0100, "glitch_e1");
        cyc(1'b1, 4'b0011, 1'b0, 4'b0111, 4'b0100, "glitch_e2");
        cyc_n(3, 4'b0011, 1'b0, 4'b0111, 4'b0100, "glitch_hold");
        cyc(1'b1, 4'b0011, 1'b0, 4'b0111, 4'b0100, "glitch_last_on");
        cyc(1'b1, 4'b0011, 1'b0, 4'b0011, 4'b0000, "glitch_off");
        cyc_n(4, 4'b0011, 1'b0, 4'b0011, 4'b0000, "glitch_off_hold");

        // ch0 off and ch3 on requested together.
        cyc(1'b1, 4'b1010, 1'b0, 4'b0011, 4'b0000, "simul_e0");
        cyc(1'b1, 4'b1010, 1'b0, 4'b0011, 4'b1001, "simul_e1");
        cyc(1'b1, 4'b1010, 1'b0, 4'b1010, 4'b0000, "simul_e2");
        cyc_n(4, 4'b1010, 1'b0, 4'b1010, 4'b0000, "simul_hold");

        // Everything off, then scan test mode.
        cyc(1'b1, 4'b0000, 1'b0, 4'b1010, 4'b0000, "alloff_e0");
        cyc(1'b1, 4'b0000, 1'b0, 4'b1010, 4'b1010, "alloff_e1");
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, "alloff_e2");
        cyc_n(4, 4'b0000, 1'b0, 4'b0000, 4'b0000, "alloff_hold");
        cyc(1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000, "test_e0");
        check_clk(4'b1111, "test_clk");
        cyc_n(2, 4'b0000, 1'b1, 4'b0000, 4'b0000, "test_ack");
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, "test_exit");
        check_clk(4'b0000, "gated_clk");

        // Reset two cycles into ch1's ON_HOLD, then a fresh request.
        cyc(1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0000, "mh_e0");
        cyc(1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0010, "mh_e1");
        cyc(1'b1, 4'b0010, 1'b0, 4'b0010, 4'b0000, "mh_e2");
        cyc_n(2, 4'b0010, 1'b0, 4'b0010, 4'b0000, "mh_in_hold");
        cyc(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0000, "mh_reset");
        cyc(1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0000, "mh_release");
        cyc(1'b1, 4'b0011, 1'b0, 4'b0001, 4'b0000, "mh_req_e0");
        cyc(1'b1, 4'b0011, 1'b0, 4'b0001, 4'b0010, "mh_req_e1");
        cyc(1'b1, 4'b0011, 1'b0, 4'b0011, 4'b0000, "mh_req_e2");
        cyc_n(4, 4'b0011, 1'b0, 4'b0011, 4'b0000, "mh_req_hold");
        cyc(1'b1, 4'b0001, 1'b0, 4'b0011, 4'b0000, "mh_drop_e0");
        cyc(1'b1, 4'b0001, 1'b0, 4'b0011, 4'b0010, "mh_drop_e1");
        cyc(1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0000, "mh_drop_e2");

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulp_clock_gating_async_mc.md
PULP_CLOCK_GATING_ASYNC_MC -- requirements
Module: pulp_clock_gating_async_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent gated-clock channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, enable synchronizer depth (2..4).
REQ-003 SHALL have parameter MIN_DWELL, default 4, minimum hold cycles after any gate change (0..255).
REQ-004 SHALL have parameter RST_VAL, default '0, NUM_CH-bit per-channel gate state applied at reset.
REQ-005 SHALL have port clk_i, input, 1, single clock; all logic in this domain.
REQ-006 SHALL have port rstn_i, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port en_async_i, input, NUM_CH, per-channel asynchronous enable request.
REQ-008 SHALL have port test_en_i, input, 1, forces all clk_o ungated (scan/test).
REQ-009 SHALL have port en_ack_o, output, NUM_CH, current registered gate state per channel.
REQ-010 SHALL have port busy_o, output, NUM_CH, synchronized request differs from gate state.
REQ-011 SHALL have port clk_o, output, NUM_CH, gated clock per channel.

Function
REQ-012 Each channel SHALL synchronize en_async_i[i] through SYNC_STAGES flops; en_sync[i] is the last stage.
REQ-013 Each channel SHALL run a 4-state FSM: OFF, ON, OFF_HOLD, ON_HOLD; gate_q=1 in ON and ON_HOLD.
REQ-014 OFF with en_sync=1 SHALL go to ON_HOLD, cnt=MIN_DWELL; when MIN_DWELL=0 it SHALL go directly to ON.
REQ-015 ON with en_sync=0 SHALL go to OFF_HOLD, cnt=MIN_DWELL; when MIN_DWELL=0 it SHALL go directly to OFF.
REQ-016 In HOLD states cnt SHALL decrement by 1 per cycle, and en_sync SHALL be ignored.
REQ-017 At cnt==1, ON_HOLD SHALL go to ON and OFF_HOLD SHALL go to OFF, with cnt becoming 0.
REQ-018 The cnt width SHALL be max(1, $clog2(MIN_DWELL+1)), and cnt SHALL never underflow.
REQ-019 Latency from an en_async_i edge (setup met) to en_ack_o SHALL be SYNC_STAGES+1 clk_i edges when the channel is not in HOLD.
REQ-020 Any gate change SHALL persist for at least MIN_DWELL+1 cycles, so request pulses shorter than this are stretched, not dropped.
REQ-021 A request toggling back during HOLD SHALL be evaluated only after HOLD ends.
REQ-022 busy_o[i] SHALL equal (en_sync[i] != gate_q[i]), combinationally from registers.
REQ-023 en_ack_o[i] SHALL equal gate_q[i].
REQ-024 clk_o[i] SHALL be produced by the latch-based leaf gate pulp_clock_gating with en_i=gate_q[i] and test_en_i shared, glitch-free.
REQ-025 test_en_i SHALL affect only clk_o and SHALL NOT change en_ack_o, busy_o or FSM state.
REQ-026 Channels SHALL be fully independent, and simultaneous changes on several channels SHALL occur on the same edge.

Reset
REQ-027 While rstn_i=0 at a clk_i edge, synchronizer flops[i] and gate_q[i] SHALL load RST_VAL[i], cnt SHALL load 0, and the state SHALL be ON or OFF per RST_VAL[i].
REQ-028 Reset asserted mid-HOLD SHALL abort the hold at the next edge with no residual dwell.
REQ-029 Outputs after reset SHALL be en_ack_o=RST_VAL and busy_o=0; clk_o[i] SHALL toggle only where RST_VAL[i]=1 (or test_en_i=1).

Structure
REQ-030 Package pulp_clk_gate_pkg SHALL hold the FSM state enum (OFF, ON, OFF_HOLD, ON_HOLD) and the parameter limit constants.
REQ-031 Per-channel logic (synchronizer, FSM, counter, leaf gate) SHALL be sub-module pulp_clock_gating_async_ch, instantiated NUM_CH times in a generate loop.
REQ-032 Parameter ranges SHALL be checked by elaboration-time assertions.

Verification (NUM_CH=4, SYNC_STAGES=2, MIN_DWELL=4)
REQ-033 Reset: RST_VAL=4'b0001, rstn_i=0 for 3 cycles -> en_ack_o=4'b0001, busy_o=0, only clk_o[0] toggling.
REQ-034 Turn-on: en_async_i[1] rises before edge 0 -> busy_o[1]=1 after edge 1, en_ack_o[1]=1 after edge 2; en_ack_o[1] SHALL NOT rise after edge 1.
REQ-035 Glitch: en_async_i[2] high for 1 cycle -> en_ack_o[2] high for exactly 5 cycles, then low; busy_o[2] high during the final ON cycle.
REQ-036 Simultaneous: ch0 request 1->0 and ch3 request 0->1 on the same cycle -> both en_ack_o bits change on the same edge.
REQ-037 Test mode: test_en_i=1, en_async_i=0 -> all four clk_o toggle and en_ack_o stays 4'b0000.
REQ-038 Mid-hold reset: reset asserted 2 cycles into ON_HOLD on ch1 -> next edge en_ack_o[1]=RST_VAL[1]; a new request after deassertion sees SYNC_STAGES+1 latency with no residual hold.
